mul8_io_sequencer: RTL and testbench
====================================

Name: mul8_io_sequencer

Overview:
Byte-serial front/back end for the 8x8 Vedic multiplier on the 8-bit TinyTapeout pin budget. It captures operand A, then operand B, from one 8-bit input bus with a valid/ready handshake, and drives them onto the multiplier operand lines. After a programmable settle time it registers the multiplier's low and high product bytes. It then returns them as two beats on an 8-bit valid/ready output bus. The multiplier stays combinational and external to this block: mul_a/mul_b feed it, and its low/high product bytes return on mul_lo/mul_hi.

Parameters:
SETTLE_CYCLES, 1, clock edges between accepting B and sampling the product; legal range 1..15.
HI_FIRST, 0, 0 = output low byte then high byte; 1 = high byte then low byte.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset; asynchronous, active-low
clr  input  1  synchronous abort, highest priority after reset
in_data  input  8  operand byte
in_valid  input  1  in_data valid
in_ready  output  1  block accepts an operand byte this cycle
out_data  output  8  product byte
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
out_sel  output  1  0 = out_data is product[7:0], 1 = product[15:8]
busy  output  1  transaction in progress (state != LOAD_A)
mul_a  output  8  registered operand A to multiplier
mul_b  output  8  registered operand B to multiplier
mul_lo  input  8  multiplier product[7:0]
mul_hi  input  8  multiplier product[15:8]

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous, active-low.
  - Reset values: state LOAD_A, a_reg/b_reg/prod_reg 0, settle counter 0.
  - Resulting outputs in reset: in_ready 1, out_valid 0, out_data 0x00, out_sel 0, busy 0, mul_a 0x00, mul_b 0x00.
- Handshakes:
  - A transfer occurs on a rising edge where valid and ready are both 1.
  - All outputs are Moore decodes of registers; there are no combinational paths from in_valid/out_ready.
- FSM:
  - LOAD_A: in_ready=1. On transfer, a_reg<=in_data -> LOAD_B.
  - LOAD_B: in_ready=1. On transfer, b_reg<=in_data, cnt<=SETTLE_CYCLES-1 -> SETTLE.
  - SETTLE: in_ready=0. If cnt==0: prod_reg<={mul_hi,mul_lo} -> OUT_1. Otherwise cnt<=cnt-1.
  - OUT_1: out_valid=1, first byte per HI_FIRST. On transfer -> OUT_2.
  - OUT_2: out_valid=1, second byte. On transfer -> LOAD_A.
- Timing:
  - mul_a=a_reg and mul_b=b_reg at all times.
  - Product sampled exactly SETTLE_CYCLES edges after the edge that accepted B.
  - out_valid rises on that same edge.
  - Minimum transaction: 2 input beats + SETTLE_CYCLES + 2 output beats.
- Output data:
  - out_data = 0x00 whenever out_valid=0.
  - out_data and out_sel hold stable while out_valid=1 and out_ready=0.
  - out_sel=1 exactly when the high byte is presented.
- Ignored inputs:
  - in_valid is ignored in SETTLE/OUT_1/OUT_2 (in_ready=0); no operand is lost or pre-loaded.
  - out_ready is ignored when out_valid=0.
- Back-to-back: the cycle after the OUT_2 transfer the block is in LOAD_A with in_ready=1. If in_valid is held high, the next byte is taken as the new A.
- clr:
  - Returns the FSM to LOAD_A from any state next edge and zeroes a_reg, b_reg, prod_reg and cnt.
  - Any partially delivered product is discarded.
  - clr overrides a simultaneous handshake: that byte is not accepted and the output beat does not count.
- Reset mid-operation: immediate return to reset values regardless of state; no partial output is completed.
- mul_a/mul_b change only on accept edges or clr/reset; the multiplier inputs are otherwise stable through SETTLE.
- Arithmetic: unsigned 8x8 -> 16-bit, computed externally; the block never alters product bits.

Test Plan:
- A=0x0D, B=0x0B, SETTLE_CYCLES=1, out_ready=1 -> out_valid one edge after B accept; beats 0x8F (out_sel 0) then 0x00 (out_sel 1); busy falls after the second beat.
- A=0xFF, B=0xFF, out_ready held 0 for 5 cycles in OUT_1 -> out_data stays 0x01, out_sel stays 0; in_valid=1 during this time is not accepted. Release gives 0x01 then 0xFE.
- SETTLE_CYCLES=3, multiplier model whose output becomes correct 2 cycles after B changes, A=0x12, B=0x34 -> captured 0x03A8; out_valid exactly 3 edges after B accept.
- HI_FIRST=1, A=0x80, B=0x02 -> beats 0x01 (out_sel 1) then 0x00 (out_sel 0). Back-to-back second transaction with in_valid held high: A=0x03, B=0x05 -> 0x00 then 0x0F, with no idle cycle required.
- clr asserted in OUT_2 with out_ready=1 -> no beat counted; next cycle in_ready=1, out_valid=0, mul_a=mul_b=0x00; the next byte is accepted as A.
- rst_n low for 1 cycle mid-SETTLE -> reset values seen asynchronously; after release, a fresh A=0x07, B=0x09 produces 0x3F then 0x00.

Source files
------------

// File: rtl/mul8_io_sequencer.sv
// Byte-serial operand loader and product unloader for an external combinational
// 8x8 multiplier: A then B in, settle, then two product bytes out.
module mul8_io_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter bit          HI_FIRST      = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_sel,
   output logic       busy,
   output logic [7:0] mul_a,
   output logic [7:0] mul_b,
   input  logic [7:0] mul_lo,
   input  logic [7:0] mul_hi
);

   typedef enum logic [2:0] {
      LOAD_A,
      LOAD_B,
      SETTLE,
      OUT_1,
      OUT_2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t      state, state_nxt;
   logic [7:0]  a_reg, a_nxt;
   logic [7:0]  b_reg, b_nxt;
   logic [15:0] prod_reg, prod_nxt;
   logic [3:0]  cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= LOAD_A;
         a_reg    <= 8'h00;
         b_reg    <= 8'h00;
         prod_reg <= 16'h0000;
         cnt      <= 4'd0;
      end else begin
         state    <= state_nxt;
         a_reg    <= a_nxt;
         b_reg    <= b_nxt;
         prod_reg <= prod_nxt;
         cnt      <= cnt_nxt;
      end
   end

   // clr wins over any handshake in the same cycle, so a beat taken under clr never counts
   always_comb begin
      state_nxt = state;
      a_nxt     = a_reg;
      b_nxt     = b_reg;
      prod_nxt  = prod_reg;
      cnt_nxt   = cnt;
      if (clr) begin
         state_nxt = LOAD_A;
         a_nxt     = 8'h00;
         b_nxt     = 8'h00;
         prod_nxt  = 16'h0000;
         cnt_nxt   = 4'd0;
      end else begin
         case (state)
            LOAD_A: if (in_valid) begin
               a_nxt     = in_data;
               state_nxt = LOAD_B;
            end
            LOAD_B: if (in_valid) begin
               b_nxt     = in_data;
               cnt_nxt   = CNT_LOAD;
               state_nxt = SETTLE;
            end
            SETTLE: if (cnt == 4'd0) begin
               prod_nxt  = {mul_hi, mul_lo};
               state_nxt = OUT_1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
            OUT_1: if (out_ready) state_nxt = OUT_2;
            OUT_2: if (out_ready) state_nxt = LOAD_A;
            default: state_nxt = LOAD_A;
         endcase
      end
   end

   // Pure state decodes: nothing below depends on in_valid or out_ready
   assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
   assign out_valid = (state == OUT_1) || (state == OUT_2);
   assign busy      = (state != LOAD_A);
   assign out_sel   = (state == OUT_1) ? HI_FIRST :
                      (state == OUT_2) ? ~HI_FIRST : 1'b0;
   assign out_data  = !out_valid ? 8'h00 :
                      out_sel    ? prod_reg[15:8] : prod_reg[7:0];
   assign mul_a     = a_reg;
   assign mul_b     = b_reg;

endmodule

// File: tb/tb_mul8_io_sequencer.sv
// Bench for mul8_io_sequencer: two instances (fast settle / low-first, slow settle /
// high-first with a lagging multiplier) driven by scenario tasks and random traffic.
module tb_mul8_io_sequencer;

   localparam int SET0 = 1;
   localparam int SET1 = 3;
   localparam bit HI0  = 1'b0;
   localparam bit HI1  = 1'b1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       clr       [2];
   logic [7:0] in_data   [2];
   logic       in_valid  [2];
   logic       in_ready  [2];
   logic [7:0] out_data  [2];
   logic       out_valid [2];
   logic       out_ready [2];
   logic       out_sel   [2];
   logic       busy      [2];
   logic [7:0] mul_a     [2];
   logic [7:0] mul_b     [2];
   logic [7:0] mul_lo    [2];
   logic [7:0] mul_hi    [2];

   int tests = 0;
   int fails = 0;

   // Instance 0 sees an ideal combinational multiplier
   logic [15:0] p0;
   assign p0        = 16'(mul_a[0]) * 16'(mul_b[0]);
   assign mul_lo[0] = p0[7:0];
   assign mul_hi[0] = p0[15:8];

   // Instance 1 sees a multiplier whose output is correct only 2 edges after its inputs change
   logic [15:0] p_d1, p_d2;
   always_ff @(posedge clk) begin
      p_d1 <= 16'(mul_a[1]) * 16'(mul_b[1]);
      p_d2 <= p_d1;
   end
   assign mul_lo[1] = p_d2[7:0];
   assign mul_hi[1] = p_d2[15:8];

   mul8_io_sequencer #(.SETTLE_CYCLES(SET0), .HI_FIRST(HI0)) dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr[0]),
      .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_sel(out_sel[0]), .busy(busy[0]),
      .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_lo(mul_lo[0]), .mul_hi(mul_hi[0])
   );

   mul8_io_sequencer #(.SETTLE_CYCLES(SET1), .HI_FIRST(HI1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr[1]),
      .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_sel(out_sel[1]), .busy(busy[1]),
      .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_lo(mul_lo[1]), .mul_hi(mul_hi[1])
   );

   // Reference: beat k of a product, and which half it is, for a given instance
   function automatic bit hi_of(input int d);
      return (d == 0) ? HI0 : HI1;
   endfunction

   function automatic int settle_of(input int d);
      return (d == 0) ? SET0 : SET1;
   endfunction

   function automatic logic exp_sel(input int d, input int k);
      return (k == 0) ? hi_of(d) : !hi_of(d);
   endfunction

   function automatic logic [7:0] exp_byte(input int d, input logic [15:0] p, input int k);
      return exp_sel(d, k) ? p[15:8] : p[7:0];
   endfunction

   task automatic send_byte(input int d, input logic [7:0] v, input bit hold, output bit ok);
      ok = 1'b0;
      in_data[d]  = v;
      in_valid[d] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (in_ready[d]) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!hold) in_valid[d] = 1'b0;
   endtask

   task automatic wait_valid(input int d, output int n);
      n = 0;
      while (!out_valid[d] && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic take_beat(input int d, output logic [7:0] data, output logic sel);
      data = out_data[d];
      sel  = out_sel[d];
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      out_ready[d] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         clr[d] = 1'b0; in_data[d] = 8'h00; in_valid[d] = 1'b0; out_ready[d] = 1'b0;
      end
      #12;
      for (int d = 0; d < 2; d++) begin
         tests++;
         if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_data[d] !== 8'h00 ||
             out_sel[d] !== 1'b0 || busy[d] !== 1'b0 || mul_a[d] !== 8'h00 || mul_b[d] !== 8'h00) begin
            fails++;
            $display("FAIL reset_%0d: rdy=%b vld=%b data=%h sel=%b busy=%b a=%h b=%h want 1 0 00 0 0 00 00",
                     d, in_ready[d], out_valid[d], out_data[d], out_sel[d], busy[d], mul_a[d], mul_b[d]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      bit ok1, ok2;
      int n;
      logic [7:0] dt;
      logic sl;
      send_byte(0, 8'h0D, 1'b0, ok1);
      send_byte(0, 8'h0B, 1'b0, ok2);
      wait_valid(0, n);
      tests++;
      if (!(ok1 && ok2) || n !== 1) begin
         fails++; $display("FAIL basic_latency: accepted=%b%b edges=%0d want 11 1", ok1, ok2, n);
      end
      take_beat(0, dt, sl);
      tests++;
      if (dt !== 8'h8F || sl !== 1'b0) begin
         fails++; $display("FAIL basic_beat1: got %h/%b want 8f/0", dt, sl);
      end
      take_beat(0, dt, sl);
      tests++;
      if (dt !== 8'h00 || sl !== 1'b1) begin
         fails++; $display("FAIL basic_beat2: got %h/%b want 00/1", dt, sl);
      end
      tests++;
      if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || out_data[0] !== 8'h00) begin
         fails++; $display("FAIL basic_idle: busy=%b vld=%b data=%h want 0 0 00", busy[0], out_valid[0], out_data[0]);
      end
   endtask

   task automatic test_stall();
      bit ok1, ok2;
      int n;
      logic [7:0] dt;
      logic sl;
      send_byte(0, 8'hFF, 1'b0, ok1);
      send_byte(0, 8'hFF, 1'b0, ok2);
      wait_valid(0, n);
      out_ready[0] = 1'b0;
      in_data[0]   = 8'h55;
      in_valid[0]  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h01 || out_sel[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
            fails++;
            $display("FAIL stall_hold_%0d: vld=%b data=%h sel=%b rdy=%b want 1 01 0 0",
                     i, out_valid[0], out_data[0], out_sel[0], in_ready[0]);
         end
         @(posedge clk); #1;
      end
      in_valid[0] = 1'b0;
      take_beat(0, dt, sl);
      tests++;
      if (dt !== 8'h01 || sl !== 1'b0) begin
         fails++; $display("FAIL stall_beat1: got %h/%b want 01/0", dt, sl);
      end
      take_beat(0, dt, sl);
      tests++;
      if (dt !== 8'hFE || sl !== 1'b1) begin
         fails++; $display("FAIL stall_beat2: got %h/%b want fe/1", dt, sl);
      end
      tests++;
      if (mul_a[0] !== 8'hFF || mul_b[0] !== 8'hFF || busy[0] !== 1'b0) begin
         fails++; $display("FAIL stall_no_preload: a=%h b=%h busy=%b want ff ff 0", mul_a[0], mul_b[0], busy[0]);
      end
   endtask

   task automatic test_settle();
      bit ok1, ok2;
      int n;
      logic [7:0] dt;
      logic sl;
      send_byte(1, 8'h12, 1'b0, ok1);
      send_byte(1, 8'h34, 1'b0, ok2);
      wait_valid(1, n);
      tests++;
      if (!(ok1 && ok2) || n !== 3) begin
         fails++; $display("FAIL settle_latency: accepted=%b%b edges=%0d want 11 3", ok1, ok2, n);
      end
      take_beat(1, dt, sl);
      tests++;
      if (dt !== 8'h03 || sl !== 1'b1) begin
         fails++; $display("FAIL settle_beat1: got %h/%b want 03/1", dt, sl);
      end
      take_beat(1, dt, sl);
      tests++;
      if (dt !== 8'hA8 || sl !== 1'b0) begin
         fails++; $display("FAIL settle_beat2: got %h/%b want a8/0", dt, sl);
      end
   endtask

   task automatic test_back_to_back();
      bit ok1, ok2;
      int n;
      logic [7:0] dt;
      logic sl;
      send_byte(1, 8'h80, 1'b0, ok1);
      send_byte(1, 8'h02, 1'b0, ok2);
      wait_valid(1, n);
      take_beat(1, dt, sl);
      tests++;
      if (dt !== 8'h01 || sl !== 1'b1) begin
         fails++; $display("FAIL b2b_beat1: got %h/%b want 01/1", dt, sl);
      end
      in_data[1]  = 8'h03;
      in_valid[1] = 1'b1;
      take_beat(1, dt, sl);
      tests++;
      if (dt !== 8'h00 || sl !== 1'b0 || in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
         fails++;
         $display("FAIL b2b_beat2: got %h/%b rdy=%b vld=%b want 00/0 1 0", dt, sl, in_ready[1], out_valid[1]);
      end
      @(posedge clk); #1;
      tests++;
      if (mul_a[1] !== 8'h03 || busy[1] !== 1'b1) begin
         fails++; $display("FAIL b2b_new_a: a=%h busy=%b want 03 1", mul_a[1], busy[1]);
      end
      in_data[1] = 8'h05;
      @(posedge clk); #1;
      in_valid[1] = 1'b0;
      wait_valid(1, n);
      tests++;
      if (mul_b[1] !== 8'h05 || n !== 3) begin
         fails++; $display("FAIL b2b_new_b: b=%h edges=%0d want 05 3", mul_b[1], n);
      end
      take_beat(1, dt, sl);
      tests++;
      if (dt !== 8'h00 || sl !== 1'b1) begin
         fails++; $display("FAIL b2b_beat3: got %h/%b want 00/1", dt, sl);
      end
      take_beat(1, dt, sl);
      tests++;
      if (dt !== 8'h0F || sl !== 1'b0) begin
         fails++; $display("FAIL b2b_beat4: got %h/%b want 0f/0", dt, sl);
      end
   endtask

   task automatic test_clr();
      bit ok1, ok2;
      int n;
      logic [7:0] dt;
      logic sl;
      send_byte(0, 8'h5A, 1'b0, ok1);
      send_byte(0, 8'h03, 1'b0, ok2);
      wait_valid(0, n);
      take_beat(0, dt, sl);
      tests++;
      if (dt !== 8'h0E || sl !== 1'b0) begin
         fails++; $display("FAIL clr_beat1: got %h/%b want 0e/0", dt, sl);
      end
      out_ready[0] = 1'b1;
      clr[0]       = 1'b1;
      @(posedge clk); #1;
      clr[0]       = 1'b0;
      out_ready[0] = 1'b0;
      tests++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || mul_a[0] !== 8'h00 ||
          mul_b[0] !== 8'h00 || out_data[0] !== 8'h00 || busy[0] !== 1'b0) begin
         fails++;
         $display("FAIL clr_state: rdy=%b vld=%b a=%h b=%h data=%h busy=%b want 1 0 00 00 00 0",
                  in_ready[0], out_valid[0], mul_a[0], mul_b[0], out_data[0], busy[0]);
      end
      send_byte(0, 8'h21, 1'b0, ok1);
      tests++;
      if (!ok1 || mul_a[0] !== 8'h21 || mul_b[0] !== 8'h00 || busy[0] !== 1'b1) begin
         fails++; $display("FAIL clr_next_a: ok=%b a=%h b=%h busy=%b want 1 21 00 1", ok1, mul_a[0], mul_b[0], busy[0]);
      end
      send_byte(0, 8'h02, 1'b0, ok2);
      wait_valid(0, n);
      take_beat(0, dt, sl);
      tests++;
      if (dt !== 8'h42 || sl !== 1'b0) begin
         fails++; $display("FAIL clr_after: got %h/%b want 42/0", dt, sl);
      end
      take_beat(0, dt, sl);
   endtask

   task automatic test_reset_mid();
      bit ok1, ok2;
      int n;
      logic [7:0] dt;
      logic sl;
      send_byte(0, 8'h11, 1'b0, ok1);
      send_byte(0, 8'h22, 1'b0, ok2);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (busy[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 ||
          mul_a[0] !== 8'h00 || mul_b[0] !== 8'h00) begin
         fails++;
         $display("FAIL rstmid_async: busy=%b rdy=%b vld=%b a=%h b=%h want 0 1 0 00 00",
                  busy[0], in_ready[0], out_valid[0], mul_a[0], mul_b[0]);
      end
      @(posedge clk); #1;
      tests++;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         fails++; $display("FAIL rstmid_held: vld=%b busy=%b want 0 0", out_valid[0], busy[0]);
      end
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      send_byte(0, 8'h07, 1'b0, ok1);
      send_byte(0, 8'h09, 1'b0, ok2);
      wait_valid(0, n);
      take_beat(0, dt, sl);
      tests++;
      if (dt !== 8'h3F || sl !== 1'b0 || n !== 1) begin
         fails++; $display("FAIL rstmid_beat1: got %h/%b edges=%0d want 3f/0 1", dt, sl, n);
      end
      take_beat(0, dt, sl);
      tests++;
      if (dt !== 8'h00 || sl !== 1'b1) begin
         fails++; $display("FAIL rstmid_beat2: got %h/%b want 00/1", dt, sl);
      end
   endtask

   task automatic test_random(input int d, input int count);
      bit ok1, ok2;
      int n, stall;
      logic [7:0] a, b, dt;
      logic sl;
      logic [15:0] p;
      for (int t = 0; t < count; t++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         p = 16'(a) * 16'(b);
         tests++;
         if (out_valid[d] !== 1'b0 || out_data[d] !== 8'h00) begin
            fails++; $display("FAIL rand%0d_idle_%0d: vld=%b data=%h want 0 00", d, t, out_valid[d], out_data[d]);
         end
         for (int i = 0; i < int'($urandom_range(2, 0)); i++) begin @(posedge clk); #1; end
         send_byte(d, a, 1'b0, ok1);
         for (int i = 0; i < int'($urandom_range(2, 0)); i++) begin @(posedge clk); #1; end
         send_byte(d, b, 1'b0, ok2);
         wait_valid(d, n);
         tests++;
         if (!(ok1 && ok2) || n !== settle_of(d)) begin
            fails++; $display("FAIL rand%0d_latency_%0d: accepted=%b%b edges=%0d want 11 %0d", d, t, ok1, ok2, n, settle_of(d));
         end
         for (int k = 0; k < 2; k++) begin
            stall = int'($urandom_range(3, 0));
            for (int s = 0; s < stall; s++) begin
               tests++;
               if (out_valid[d] !== 1'b1 || out_data[d] !== exp_byte(d, p, k) || out_sel[d] !== exp_sel(d, k)) begin
                  fails++;
                  $display("FAIL rand%0d_stall_%0d_%0d: vld=%b data=%h sel=%b want 1 %h %b",
                           d, t, k, out_valid[d], out_data[d], out_sel[d], exp_byte(d, p, k), exp_sel(d, k));
               end
               @(posedge clk); #1;
            end
            take_beat(d, dt, sl);
            tests++;
            if (dt !== exp_byte(d, p, k) || sl !== exp_sel(d, k)) begin
               fails++;
               $display("FAIL rand%0d_beat_%0d_%0d: a=%h b=%h got %h/%b want %h/%b",
                        d, t, k, a, b, dt, sl, exp_byte(d, p, k), exp_sel(d, k));
            end
         end
         tests++;
         if (busy[d] !== 1'b0) begin
            fails++; $display("FAIL rand%0d_done_%0d: busy=%b want 0", d, t, busy[d]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_settle();
      test_back_to_back();
      test_clr();
      test_reset_mid();
      test_random(0, 20);
      test_random(1, 20);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog expired");
   end

endmodule
